// File: rtl/video_pkg.sv
// Shared video-path definitions: default raster geometry, line-fetch FSM states
// and helpers deriving line/burst word counts from the visible width.
package video_pkg;

  localparam int unsigned ACTIVE_W_DEF = 512;
  localparam int unsigned ACTIVE_H_DEF = 240;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DATA = 2'd2
  } fetch_state_t;

  // 16 pixels of 8 bits per 128-bit DDR word
  function automatic int unsigned line_words(input int unsigned active_w);
    return active_w / 16;
  endfunction

  function automatic int unsigned line_bursts(input int unsigned active_w,
                                              input int unsigned burst);
    return active_w / 16 / burst;
  endfunction

endpackage

// File: rtl/line_fetch_buf.sv
// Ping-pong scanline store: 2 banks x LINE_WORDS x 128 bit, one write port from
// DDR and one registered read port (read-before-write on address collision).
module line_fetch_buf
  import video_pkg::*;
#(
  parameter int unsigned WORDS = 2 * line_words(ACTIVE_W_DEF),
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [127:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [127:0]  rdata
);

  logic [127:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register carries the reset so the pixel path starts at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata <= '0;
    else          rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_fetch_ctrl.sv
// Scanline fetch scheduler: bursts the next visible line from DDR into a ping-pong
// buffer during hblank and serves pixels. LINE_FETCH_STATS_EN adds underrun_cnt.
module line_fetch_ctrl
  import video_pkg::*;
#(
  parameter int unsigned ACTIVE_W      = ACTIVE_W_DEF,
  parameter int unsigned ACTIVE_H      = ACTIVE_H_DEF,
  parameter int unsigned PREFETCH_LINE = 250,
  parameter int unsigned BURST         = 8,
  parameter int unsigned ADDR_W        = 28
) (
  input  logic              clk_vid,
  input  logic              reset_n,
  input  logic [10:0]       hpos,
  input  logic [9:0]        vpos,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              ddr_rd,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [7:0]        ddr_burstcnt,
  input  logic              ddr_busy,
  input  logic [127:0]      ddr_dout,
  input  logic              ddr_dout_ready,
  output logic [7:0]        pix_out,
  output logic              underrun
`ifdef LINE_FETCH_STATS_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int unsigned LINE_WORDS = line_words(ACTIVE_W);
  localparam int unsigned BURSTS     = line_bursts(ACTIVE_W, BURST);
  localparam int unsigned WORD_AW    = $clog2(LINE_WORDS);
  localparam int unsigned BURST_AW   = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam int unsigned BEAT_AW    = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [1:0] S_IDLE = FETCH_IDLE;
  localparam logic [1:0] S_REQ  = FETCH_REQ;
  localparam logic [1:0] S_DATA = FETCH_DATA;

  logic [1:0]          state;
  logic [9:0]          line;
  logic [BURST_AW-1:0] burst_idx;
  logic [BURST_AW-1:0] next_burst;
  logic [BEAT_AW-1:0]  beat_idx;
  logic                drop_pending;
  logic [9:0]          drop_line;

  logic                trig_hit;
  logic [9:0]          trig_line;
  logic                beat_last;
  logic                burst_last;
  logic                drop_evt;
  logic                line_evt;

  logic                buf_we;
  logic [WORD_AW-1:0]  wword;
  logic [127:0]        rdata;
  logic [3:0]          byte_sel;

  function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [9:0] l,
                                                   input logic [BURST_AW-1:0] b);
    return base + ADDR_W'(l) * ADDR_W'(LINE_WORDS) + ADDR_W'(b) * ADDR_W'(BURST);
  endfunction

  always_comb begin
    trig_hit  = 1'b0;
    trig_line = '0;
    if (hpos == 11'(ACTIVE_W) && fetch_en) begin
      if (vpos < 10'(ACTIVE_H - 1)) begin
        trig_hit  = 1'b1;
        trig_line = vpos + 10'd1;
      end else if (vpos == 10'(PREFETCH_LINE)) begin
        trig_hit  = 1'b1;
      end
    end
  end

  assign next_burst   = burst_idx + 1'b1;
  assign beat_last    = (beat_idx == BEAT_AW'(BURST - 1));
  assign burst_last   = (burst_idx == BURST_AW'(BURSTS - 1));
  assign ddr_rd       = (state == S_REQ);
  assign ddr_burstcnt = 8'(BURST);

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      line      <= '0;
      burst_idx <= '0;
      beat_idx  <= '0;
      ddr_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: if (trig_hit) begin
          state     <= S_REQ;
          line      <= trig_line;
          burst_idx <= '0;
          beat_idx  <= '0;
          ddr_addr  <= burst_addr(base_addr, trig_line, '0);
        end
        S_REQ: if (!ddr_busy) state <= S_DATA;
        S_DATA: if (ddr_dout_ready) begin
          if (beat_last) begin
            beat_idx <= '0;
            if (burst_last) begin
              state <= S_IDLE;
            end else begin
              burst_idx <= next_burst;
              ddr_addr  <= burst_addr(base_addr, line, next_burst);
              state     <= S_REQ;
            end
          end else begin
            beat_idx <= beat_idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A dropped trigger is remembered so the miss is also charged when that line starts
  assign drop_evt = trig_hit && (state != S_IDLE);
  assign line_evt = (hpos == '0) && (vpos < 10'(ACTIVE_H)) &&
                    ((state != S_IDLE) || (drop_pending && drop_line == vpos));

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      underrun     <= 1'b0;
      drop_pending <= 1'b0;
      drop_line    <= '0;
    end else begin
      if (drop_evt || line_evt) underrun <= 1'b1;
      if (drop_evt) begin
        drop_pending <= 1'b1;
        drop_line    <= trig_line;
      end else if (hpos == '0 && vpos < 10'(ACTIVE_H) && drop_line == vpos) begin
        drop_pending <= 1'b0;
      end
    end
  end

`ifdef LINE_FETCH_STATS_EN
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n)
      underrun_cnt <= '0;
    else if ((drop_evt || line_evt) && underrun_cnt != '1)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

  assign buf_we = (state == S_DATA) && ddr_dout_ready;
  assign wword  = WORD_AW'(burst_idx) * WORD_AW'(BURST) + WORD_AW'(beat_idx);

  line_fetch_buf #(
    .WORDS (2 * LINE_WORDS),
    .AW    (WORD_AW + 1)
  ) u_buf (
    .clk     (clk_vid),
    .reset_n (reset_n),
    .we      (buf_we),
    .waddr   ({line[0], wword}),
    .wdata   (ddr_dout),
    .raddr   ({vpos[0], hpos[4 +: WORD_AW]}),
    .rdata   (rdata)
  );

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) byte_sel <= '0;
    else          byte_sel <= hpos[3:0];
  end

  assign pix_out = rdata[{byte_sel, 3'b000} +: 8];

endmodule
